// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath select and enable.
module mips_multicycle_control #(
   parameter bit USE_MEM_READY = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [1:0] alu_op,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       mem_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       pc_en,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BEQ     = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // Pure state-decoded control bits; mem_ready/zero gating is applied afterwards.
   typedef struct packed {
      logic [1:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic       i_or_d;
      logic       fetch;
      logic       jump;
      logic       branch;
      logic       mem_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
   } ctrl_t;

   function automatic ctrl_t decode_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.alu_src_b = 2'b01;
            c.fetch     = 1'b1;
         end
         S_DECODE: begin
            c.alu_src_b = 2'b11;
         end
         S_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            c.i_or_d = 1'b1;
         end
         S_MEMWB: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
         end
         S_MEMWR: begin
            c.i_or_d    = 1'b1;
            c.mem_write = 1'b1;
         end
         S_EXECUTE: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b10;
         end
         S_ALUWB: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
         end
         S_BEQ: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b01;
            c.pc_src    = 2'b01;
            c.branch    = 1'b1;
         end
         S_ADDIEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_ADDIWB: begin
            c.reg_write = 1'b1;
         end
         S_JUMP: begin
            c.pc_src = 2'b10;
            c.jump   = 1'b1;
         end
         default: begin
            c.alu_src_b = 2'b01;
            c.fetch     = 1'b1;
         end
      endcase
      return c;
   endfunction

   function automatic logic is_legal(input logic [5:0] op);
      logic ok;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
         default:                                       ok = 1'b0;
      endcase
      return ok;
   endfunction

   state_t state_r;
   state_t state_next_s;
   ctrl_t  ctrl_r;
   logic   mem_ready_s;

   assign mem_ready_s = USE_MEM_READY ? mem_ready : 1'b1;

   // Next-state selection from the current state, IR opcode and memory handshake.
   always_comb begin
      state_next_s = S_FETCH;
      case (state_r)
         S_FETCH: begin
            if (mem_ready_s) begin
               state_next_s = S_DECODE;
            end else begin
               state_next_s = S_FETCH;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_next_s = S_MEMADR;
               OP_RTYPE:     state_next_s = S_EXECUTE;
               OP_BEQ:       state_next_s = S_BEQ;
               OP_ADDI:      state_next_s = S_ADDIEX;
               OP_J:         state_next_s = S_JUMP;
               default:      state_next_s = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (opcode == OP_LW) begin
               state_next_s = S_MEMRD;
            end else begin
               state_next_s = S_MEMWR;
            end
         end
         S_MEMRD: begin
            if (mem_ready_s) begin
               state_next_s = S_MEMWB;
            end else begin
               state_next_s = S_MEMRD;
            end
         end
         S_MEMWR: begin
            if (mem_ready_s) begin
               state_next_s = S_FETCH;
            end else begin
               state_next_s = S_MEMWR;
            end
         end
         S_EXECUTE: state_next_s = S_ALUWB;
         S_ADDIEX:  state_next_s = S_ADDIWB;
         default:   state_next_s = S_FETCH;
      endcase
   end

   // State register plus control bits pre-decoded for the state being entered,
   // so the registered controls always line up with state_r.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_FETCH;
         ctrl_r  <= decode_ctrl(S_FETCH);
      end else begin
         state_r <= state_next_s;
         ctrl_r  <= decode_ctrl(state_next_s);
      end
   end

   assign state      = state_r;
   assign alu_op     = ctrl_r.alu_op;
   assign alu_src_a  = ctrl_r.alu_src_a;
   assign alu_src_b  = ctrl_r.alu_src_b;
   assign pc_src     = ctrl_r.pc_src;
   assign i_or_d     = ctrl_r.i_or_d;
   assign reg_dst    = ctrl_r.reg_dst;
   assign mem_to_reg = ctrl_r.mem_to_reg;

   // Enables are forced low during reset regardless of registered contents.
   assign ir_write   = rst_n & ctrl_r.fetch & mem_ready_s;
   assign pc_en      = rst_n & ((ctrl_r.fetch & mem_ready_s) | ctrl_r.jump |
                                (ctrl_r.branch & zero));
   assign mem_write  = rst_n & ctrl_r.mem_write;
   assign reg_write  = rst_n & ctrl_r.reg_write;
   assign illegal_op = rst_n & (state_r == S_DECODE) & ~is_legal(opcode);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed-vector bench for mips_multicycle_control with hand-computed expectations.
module tb_mips_multicycle_control;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic [1:0] alu_op;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] pc_src;
   logic       i_or_d;
   logic       ir_write;
   logic       mem_write;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       pc_en;
   logic       illegal_op;
   logic [3:0] state;

   int tests_run = 0;
   int tests_failed = 0;

   mips_multicycle_control #(.USE_MEM_READY(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
      .i_or_d(i_or_d), .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_en(pc_en), .illegal_op(illegal_op),
      .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Advance one clock, then apply this cycle's inputs and let outputs settle.
   task automatic cyc(input logic mr, input logic z);
      @(posedge clk);
      #2;
      mem_ready = mr;
      zero      = z;
      #1;
   endtask

   // Checks common to a FETCH cycle with mem_ready high.
   task automatic check_fetch(input string tag);
      check({tag, "_state"}, {4'd0, state}, 8'd0);
      check({tag, "_ir_write"}, {7'd0, ir_write}, 8'd1);
      check({tag, "_pc_en"}, {7'd0, pc_en}, 8'd1);
      check({tag, "_alu_src_b"}, {6'd0, alu_src_b}, 8'd1);
      check({tag, "_i_or_d"}, {7'd0, i_or_d}, 8'd0);
   endtask

   initial begin
      rst_n = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
      #1;
      check("rst_state", {4'd0, state}, 8'd0);
      check("rst_ir_write", {7'd0, ir_write}, 8'd0);
      check("rst_pc_en", {7'd0, pc_en}, 8'd0);
      check("rst_reg_write", {7'd0, reg_write}, 8'd0);
      @(posedge clk); #2; rst_n = 1'b1; #1;
      check_fetch("fetch0");

      // FETCH stall: no enables, stays in FETCH
      mem_ready = 1'b0; #1;
      check("fstall_ir_write", {7'd0, ir_write}, 8'd0);
      check("fstall_pc_en", {7'd0, pc_en}, 8'd0);
      cyc(1'b1, 1'b0);
      check("fstall_state", {4'd0, state}, 8'd0);

      // R-type
      cyc(1'b1, 1'b0);
      check("r_dec_state", {4'd0, state}, 8'd1);
      check("r_dec_alu_src_b", {6'd0, alu_src_b}, 8'd3);
      check("r_dec_illegal", {7'd0, illegal_op}, 8'd0);
      cyc(1'b1, 1'b0);
      check("r_ex_state", {4'd0, state}, 8'd6);
      check("r_ex_alu_op", {6'd0, alu_op}, 8'd2);
      check("r_ex_alu_src_a", {7'd0, alu_src_a}, 8'd1);
      check("r_ex_alu_src_b", {6'd0, alu_src_b}, 8'd0);
      check("r_ex_reg_write", {7'd0, reg_write}, 8'd0);
      cyc(1'b1, 1'b0);
      check("r_wb_state", {4'd0, state}, 8'd7);
      check("r_wb_reg_write", {7'd0, reg_write}, 8'd1);
      check("r_wb_reg_dst", {7'd0, reg_dst}, 8'd1);
      check("r_wb_mem_to_reg", {7'd0, mem_to_reg}, 8'd0);
      cyc(1'b1, 1'b0);
      check_fetch("r_end");

      // lw with two stall cycles in MEMRD
      opcode = 6'b100011;
      cyc(1'b1, 1'b0);
      check("lw_dec_state", {4'd0, state}, 8'd1);
      cyc(1'b1, 1'b0);
      check("lw_adr_state", {4'd0, state}, 8'd2);
      check("lw_adr_alu_src_b", {6'd0, alu_src_b}, 8'd2);
      check("lw_adr_alu_src_a", {7'd0, alu_src_a}, 8'd1);
      for (int i = 0; i < 3; i++) begin
         cyc((i == 2) ? 1'b1 : 1'b0, 1'b0);
         check($sformatf("lw_rd%0d_state", i), {4'd0, state}, 8'd3);
         check($sformatf("lw_rd%0d_i_or_d", i), {7'd0, i_or_d}, 8'd1);
         check($sformatf("lw_rd%0d_reg_write", i), {7'd0, reg_write}, 8'd0);
      end
      cyc(1'b1, 1'b0);
      check("lw_wb_state", {4'd0, state}, 8'd4);
      check("lw_wb_reg_write", {7'd0, reg_write}, 8'd1);
      check("lw_wb_mem_to_reg", {7'd0, mem_to_reg}, 8'd1);
      check("lw_wb_reg_dst", {7'd0, reg_dst}, 8'd0);
      cyc(1'b1, 1'b0);
      check_fetch("lw_end");

      // sw with one stall cycle in MEMWR
      opcode = 6'b101011;
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      check("sw_adr_state", {4'd0, state}, 8'd2);
      check("sw_adr_mem_write", {7'd0, mem_write}, 8'd0);
      cyc(1'b0, 1'b0);
      check("sw_wr0_state", {4'd0, state}, 8'd5);
      check("sw_wr0_mem_write", {7'd0, mem_write}, 8'd1);
      check("sw_wr0_i_or_d", {7'd0, i_or_d}, 8'd1);
      check("sw_wr0_reg_write", {7'd0, reg_write}, 8'd0);
      cyc(1'b1, 1'b0);
      check("sw_wr1_state", {4'd0, state}, 8'd5);
      check("sw_wr1_mem_write", {7'd0, mem_write}, 8'd1);
      cyc(1'b1, 1'b0);
      check_fetch("sw_end");
      check("sw_end_mem_write", {7'd0, mem_write}, 8'd0);

      // beq taken then not taken
      opcode = 6'b000100;
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b1);
      check("beqt_state", {4'd0, state}, 8'd8);
      check("beqt_pc_en", {7'd0, pc_en}, 8'd1);
      check("beqt_pc_src", {6'd0, pc_src}, 8'd1);
      check("beqt_alu_op", {6'd0, alu_op}, 8'd1);
      cyc(1'b1, 1'b0);
      check_fetch("beqt_end");
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      check("beqn_state", {4'd0, state}, 8'd8);
      check("beqn_pc_en", {7'd0, pc_en}, 8'd0);
      check("beqn_alu_op", {6'd0, alu_op}, 8'd1);
      cyc(1'b1, 1'b0);
      check("beqn_end_state", {4'd0, state}, 8'd0);

      // jump
      opcode = 6'b000010;
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      check("j_state", {4'd0, state}, 8'd11);
      check("j_pc_src", {6'd0, pc_src}, 8'd2);
      check("j_pc_en", {7'd0, pc_en}, 8'd1);
      cyc(1'b1, 1'b0);
      check("j_end_state", {4'd0, state}, 8'd0);

      // addi
      opcode = 6'b001000;
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      check("addi_ex_state", {4'd0, state}, 8'd9);
      check("addi_ex_alu_src_b", {6'd0, alu_src_b}, 8'd2);
      check("addi_ex_alu_op", {6'd0, alu_op}, 8'd0);
      cyc(1'b1, 1'b0);
      check("addi_wb_state", {4'd0, state}, 8'd10);
      check("addi_wb_reg_write", {7'd0, reg_write}, 8'd1);
      check("addi_wb_reg_dst", {7'd0, reg_dst}, 8'd0);
      cyc(1'b1, 1'b0);
      check("addi_end_state", {4'd0, state}, 8'd0);

      // illegal opcode
      opcode = 6'b111111;
      cyc(1'b1, 1'b0);
      check("ill_state", {4'd0, state}, 8'd1);
      check("ill_illegal_op", {7'd0, illegal_op}, 8'd1);
      check("ill_reg_write", {7'd0, reg_write}, 8'd0);
      check("ill_mem_write", {7'd0, mem_write}, 8'd0);
      check("ill_pc_en", {7'd0, pc_en}, 8'd0);
      check("ill_ir_write", {7'd0, ir_write}, 8'd0);
      cyc(1'b1, 1'b0);
      check("ill_next_state", {4'd0, state}, 8'd0);
      check("ill_next_illegal_op", {7'd0, illegal_op}, 8'd0);

      // asynchronous reset pulse in the middle of ALUWB
      opcode = 6'b000000;
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      check("arst_pre_state", {4'd0, state}, 8'd7);
      rst_n = 1'b0; #1;
      check("arst_state", {4'd0, state}, 8'd0);
      check("arst_reg_write", {7'd0, reg_write}, 8'd0);
      check("arst_pc_en", {7'd0, pc_en}, 8'd0);
      #2; rst_n = 1'b1; #1;
      check_fetch("arst_rel");
      cyc(1'b1, 1'b0);
      check("arst_dec_state", {4'd0, state}, 8'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
